// File: rtl/ldpc_enc_if.sv
// Stream interface for the LDPC encoder: information blocks in, codeword out.
// The slave modport is the encoder side; the master modport is the producer/consumer side.
interface ldpc_enc_if #(
   parameter int unsigned R = 24,
   parameter int unsigned D = 24
);
   logic [D-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic [R*D-1:0] cw;
   logic           cw_valid;
   logic           cw_ready;

   modport master (
      output in_data, in_valid, cw_ready,
      input  in_ready, cw, cw_valid
   );

   modport slave (
      input  in_data, in_valid, cw_ready,
      output in_ready, cw, cw_valid
   );
endinterface

// File: rtl/ldpc_enc.sv
// Systematic QC-LDPC encoder: streams KB information blocks and accumulates
// the C parity blocks as XORs of circulant rotations, then holds the codeword.
module ldpc_enc #(
   parameter int unsigned data_w = 8,
   parameter int unsigned R      = 24,
   parameter int unsigned C      = 12,
   parameter int unsigned D      = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [C*R*data_w-1:0]   mtx,
   ldpc_enc_if.slave               bus,
   output logic [1:0]              status
);
   localparam int unsigned KB = R - C;
   localparam int unsigned CW = $clog2(KB) + 1;
   localparam logic [data_w:0] D_LIM = (data_w + 1)'(D);

   typedef enum logic {ACC, DONE} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt;
   logic [R*D-1:0]  cw_q;
   logic [C*D-1:0]  par_next;
   logic [data_w-1:0] sel;
   logic            accept, consume, last;
   logic            unused_mtx;

   // Only the information columns (j < KB) of mtx are ever read.
   assign unused_mtx = ^mtx;
   assign bus.cw     = cw_q;

   // out[k] = x[(k+v) mod D]; shifts of D or more give the zero block.
   function automatic logic [D-1:0] rot(input logic [D-1:0] x, input logic [data_w-1:0] v);
      logic [2*D-1:0] xx;
      xx = {x, x} >> v;
      return ({1'b0, v} < D_LIM) ? xx[D-1:0] : '0;
   endfunction

   always_comb begin
      sel      = '0;
      par_next = '0;
      for (int unsigned i = 0; i < C; i++) begin
         sel = '0;
         for (int unsigned j = 0; j < KB; j++) begin
            if (cnt == CW'(j)) sel = mtx[(i*R + j)*data_w +: data_w];
         end
         par_next[i*D +: D] = cw_q[(KB + i)*D +: D] ^ rot(bus.in_data, sel);
      end
   end

   always_comb begin
      state_next   = state;
      accept       = 1'b0;
      consume      = 1'b0;
      bus.in_ready = 1'b0;
      bus.cw_valid = 1'b0;
      status       = 2'b00;
      last         = (cnt == CW'(KB - 1));
      unique case (state)
         ACC: begin
            bus.in_ready = en;
            accept       = en & bus.in_valid;
            status       = (cnt == '0) ? 2'b00 : 2'b01;
            if (accept && last) state_next = DONE;
         end
         DONE: begin
            bus.cw_valid = 1'b1;
            status       = 2'b10;
            consume      = en & bus.cw_ready;
            if (consume) state_next = ACC;
         end
         default: state_next = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ACC;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         cw_q <= '0;
      end else if (accept) begin
         for (int unsigned j = 0; j < KB; j++) begin
            if (cnt == CW'(j)) cw_q[j*D +: D] <= bus.in_data;
         end
         cw_q[KB*D +: C*D] <= par_next;
         cnt               <= cnt + CW'(1);
      end else if (consume) begin
         // Information region is left stale; every block is rewritten next codeword.
         cnt               <= '0;
         cw_q[KB*D +: C*D] <= '0;
      end
   end
endmodule

// File: tb/tb_ldpc_enc.sv
// Self-checking bench for ldpc_enc: hand-computed small-code vectors, corner
// sequences, and randomized default-size codewords against a bitwise model.
module tb_ldpc_enc;
   localparam int RL  = 24;
   localparam int CL  = 12;
   localparam int DL  = 24;
   localparam int KBL = 12;
   localparam int WL  = 8;

   logic clk = 1'b0;
   logic rst, en;
   logic [23:0]          mtx_s;
   logic [15:0]          mtx_k;
   logic [CL*RL*WL-1:0]  mtx_l;
   logic [1:0]           st_s, st_k, st_l;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ldpc_enc_if #(.R(3),  .D(4))  s_if ();
   ldpc_enc_if #(.R(2),  .D(4))  k_if ();
   ldpc_enc_if #(.R(RL), .D(DL)) l_if ();

   ldpc_enc #(.data_w(8), .R(3), .C(1), .D(4)) dut_s (
      .clk(clk), .rst(rst), .en(en), .mtx(mtx_s), .bus(s_if), .status(st_s));
   ldpc_enc #(.data_w(8), .R(2), .C(1), .D(4)) dut_k (
      .clk(clk), .rst(rst), .en(en), .mtx(mtx_k), .bus(k_if), .status(st_k));
   ldpc_enc #(.data_w(WL), .R(RL), .C(CL), .D(DL)) dut_l (
      .clk(clk), .rst(rst), .en(en), .mtx(mtx_l), .bus(l_if), .status(st_l));

   typedef struct {
      logic [7:0]  sh0;
      logic [7:0]  sh1;
      logic [3:0]  b0;
      logic [3:0]  b1;
      logic [11:0] exp;
   } vec_t;
   vec_t tab [6];

   task automatic chk(input string name, input logic [RL*DL-1:0] act, input logic [RL*DL-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_s(input logic [3:0] b);
      int n;
      n = 0;
      s_if.in_data  = b;
      s_if.in_valid = 1'b1;
      while (!s_if.in_ready && n < 50) begin step(); n++; end
      if (n >= 50) chk("s_send_timeout", s_if.in_ready, 1);
      step();
      s_if.in_valid = 1'b0;
   endtask

   task automatic send_k(input logic [3:0] b);
      int n;
      n = 0;
      k_if.in_data  = b;
      k_if.in_valid = 1'b1;
      while (!k_if.in_ready && n < 50) begin step(); n++; end
      if (n >= 50) chk("k_send_timeout", k_if.in_ready, 1);
      step();
      k_if.in_valid = 1'b0;
   endtask

   task automatic send_l(input logic [DL-1:0] b, input int gap);
      int n;
      n = 0;
      repeat (gap) step();
      l_if.in_data  = b;
      l_if.in_valid = 1'b1;
      while (!l_if.in_ready && n < 50) begin step(); n++; end
      if (n >= 50) chk("l_send_timeout", l_if.in_ready, 1);
      step();
      l_if.in_valid = 1'b0;
   endtask

   // Parity block i = XOR over j of the circulant image of block j, bit by bit.
   function automatic logic [RL*DL-1:0] ref_cw(input logic [DL-1:0] blk [KBL],
                                               input logic [CL*RL*WL-1:0] m);
      logic [RL*DL-1:0] r;
      logic [DL-1:0]    p;
      int               v;
      r = '0;
      for (int j = 0; j < KBL; j++) r[j*DL +: DL] = blk[j];
      for (int i = 0; i < CL; i++) begin
         p = '0;
         for (int j = 0; j < KBL; j++) begin
            v = int'(m[(i*RL + j)*WL +: WL]);
            if (v < DL) begin
               for (int k = 0; k < DL; k++) p[k] = p[k] ^ blk[j][(k + v) % DL];
            end
         end
         r[(KBL + i)*DL +: DL] = p;
      end
      return r;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DL-1:0] blk [KBL];
      logic [RL*DL-1:0] expv;

      tab[0] = '{sh0: 8'd1, sh1: 8'd0,    b0: 4'h1, b1: 4'h2, exp: 12'hA21};
      tab[1] = '{sh0: 8'd1, sh1: 8'hFF,   b0: 4'h1, b1: 4'h2, exp: 12'h821};
      tab[2] = '{sh0: 8'd0, sh1: 8'd0,    b0: 4'h3, b1: 4'h5, exp: 12'h653};
      tab[3] = '{sh0: 8'd2, sh1: 8'd3,    b0: 4'h1, b1: 4'h8, exp: 12'h581};
      tab[4] = '{sh0: 8'd4, sh1: 8'd1,    b0: 4'hF, b1: 4'h1, exp: 12'h81F};
      tab[5] = '{sh0: 8'd3, sh1: 8'd2,    b0: 4'hA, b1: 4'hC, exp: 12'h6CA};

      rst = 1'b1;
      en  = 1'b1;
      mtx_s = '0; mtx_k = '0; mtx_l = '0;
      s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.cw_ready = 1'b0;
      k_if.in_valid = 1'b0; k_if.in_data = '0; k_if.cw_ready = 1'b0;
      l_if.in_valid = 1'b0; l_if.in_data = '0; l_if.cw_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_cw", s_if.cw, 0);
      chk("rst_cw_valid", s_if.cw_valid, 0);
      chk("rst_status", st_s, 2'b00);
      chk("rst_in_ready", s_if.in_ready, 1);
      chk("rst_cw_l", l_if.cw, 0);

      for (int t = 0; t < 6; t++) begin
         mtx_s = {8'h00, tab[t].sh1, tab[t].sh0};
         send_s(tab[t].b0);
         chk($sformatf("vec%0d_status_acc", t), st_s, 2'b01);
         chk($sformatf("vec%0d_no_early_valid", t), s_if.cw_valid, 0);
         send_s(tab[t].b1);
         chk($sformatf("vec%0d_valid", t), s_if.cw_valid, 1);
         chk($sformatf("vec%0d_cw", t), s_if.cw, tab[t].exp);
         chk($sformatf("vec%0d_status_done", t), st_s, 2'b10);
         s_if.cw_ready = 1'b1;
         step();
         s_if.cw_ready = 1'b0;
         chk($sformatf("vec%0d_status_idle", t), st_s, 2'b00);
      end

      // Stalls via en and in_valid, then back-pressure on the output.
      mtx_s = 24'h000001;
      s_if.cw_ready = 1'b1;
      step();
      chk("ready_ignored_status", st_s, 2'b00);
      chk("ready_ignored_valid", s_if.cw_valid, 0);
      s_if.cw_ready = 1'b0;
      s_if.in_data  = 4'h1;
      s_if.in_valid = 1'b1;
      en = 1'b0;
      step(); step();
      chk("stall_en_status", st_s, 2'b00);
      chk("stall_en_in_ready", s_if.in_ready, 0);
      en = 1'b1;
      step();
      chk("stall_accept_status", st_s, 2'b01);
      s_if.in_valid = 1'b0;
      s_if.in_data  = 4'hF;
      step(); step();
      chk("stall_valid_status", st_s, 2'b01);
      chk("partial_parity", s_if.cw[11:8], 4'h8);
      s_if.in_data  = 4'h2;
      s_if.in_valid = 1'b1;
      en = 1'b0;
      step();
      chk("stall_en2_status", st_s, 2'b01);
      en = 1'b1;
      step();
      s_if.in_data = 4'h7;
      chk("stalled_cw", s_if.cw, 12'hA21);
      for (int c = 0; c < 5; c++) begin
         step();
         chk($sformatf("hold%0d_cw", c), s_if.cw, 12'hA21);
         chk($sformatf("hold%0d_in_ready", c), s_if.in_ready, 0);
      end
      s_if.cw_ready = 1'b1;
      en = 1'b0;
      step();
      chk("consume_needs_en", s_if.cw_valid, 1);
      en = 1'b1;
      step();
      s_if.cw_ready = 1'b0;
      chk("parity_cleared", s_if.cw[11:8], 4'h0);
      chk("info_stale", s_if.cw[7:0], 8'h21);
      chk("consume_status", st_s, 2'b00);
      s_if.in_valid = 1'b0;

      // Single information block per codeword.
      mtx_k = 16'h0001;
      send_k(4'h3);
      chk("kb1_valid", k_if.cw_valid, 1);
      chk("kb1_status", st_k, 2'b10);
      chk("kb1_cw", k_if.cw, 8'h93);
      k_if.cw_ready = 1'b1; step(); k_if.cw_ready = 1'b0;
      mtx_k = 16'h0005;
      send_k(4'h3);
      chk("kb1_zero_cw", k_if.cw, 8'h03);
      k_if.cw_ready = 1'b1; step(); k_if.cw_ready = 1'b0;

      // Reset mid-codeword, then a full codeword.
      for (int e = 0; e < CL*RL; e++) mtx_l[e*WL +: WL] = 8'($urandom_range(0, 27));
      for (int j = 0; j < 5; j++) send_l(DL'($urandom), 0);
      chk("mid_status", st_l, 2'b01);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_status", st_l, 2'b00);
      chk("mid_rst_cw", l_if.cw, 0);
      for (int j = 0; j < KBL; j++) begin
         blk[j] = DL'($urandom);
         send_l(blk[j], 0);
      end
      expv = ref_cw(blk, mtx_l);
      chk("after_rst_valid", l_if.cw_valid, 1);
      chk("after_rst_cw", l_if.cw, expv);
      l_if.cw_ready = 1'b1; step(); l_if.cw_ready = 1'b0;

      for (int n = 0; n < 20; n++) begin
         for (int e = 0; e < CL*RL; e++) mtx_l[e*WL +: WL] = 8'($urandom_range(0, 27));
         for (int j = 0; j < KBL; j++) begin
            blk[j] = DL'($urandom);
            send_l(blk[j], int'($urandom_range(0, 2)));
         end
         expv = ref_cw(blk, mtx_l);
         repeat ($urandom_range(0, 3)) step();
         chk($sformatf("rand%0d_valid", n), l_if.cw_valid, 1);
         chk($sformatf("rand%0d_cw", n), l_if.cw, expv);
         l_if.cw_ready = 1'b1; step(); l_if.cw_ready = 1'b0;
         chk($sformatf("rand%0d_parity_cleared", n), l_if.cw[RL*DL-1:KBL*DL], 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ldpc_enc.md
# ldpc_enc

Systematic QC-LDPC encoder producing codewords in the same quasi-cyclic format the `ldpc_core` decoder consumes. Information bits arrive as a stream of D-bit blocks. Parity is accumulated on the fly from a circulant shift matrix with the same layout as the decoder's `mtx` input. The completed R*D-bit codeword is presented on a valid/ready output. The parity part of H is fixed to a block-diagonal identity, so parity block i = XOR over j of rot(s_j, shift[i][j]).

## Interface
- data_w, 8, width of one circulant shift entry
- R, 24, block columns (codeword = R*D bits)
- C, 12, block rows = parity blocks
- D, 24, circulant size in bits
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable; no state change and no handshake completes while low
- mtx  input  C*R*data_w  shift for (row i, block column j) at [(i*R+j)*data_w +: data_w]; only j < R-C read
- in_data  input  D  information block s_j
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepted when in_valid & in_ready
- cw  output  R*D  codeword register
- cw_valid  output  1  cw holds a complete codeword
- cw_ready  input  1  consumer takes cw when cw_valid & cw_ready & en
- status  output  2  00 idle, 01 accumulating, 10 codeword pending

## Operation
- KB = R-C information blocks per codeword. Block counter width = clog2(KB)+1.
- States:
  - ACC: counter 0..KB-1.
  - DONE: codeword pending.
- Shift entry v < D selects circulant rot(x,v): out[k] = x[(k+v) mod D]. v ≥ D selects the all-zero block.
- Accepted beat in ACC with counter j:
  - cw[j*D +: D] <= in_data.
  - For every i in 0..C-1: cw[(KB+i)*D +: D] ^= rot(in_data, mtx[i][j]), all C rows updated in parallel in the same cycle.
  - Counter increments.
- Last block accepted (j = KB-1): same edge updates parity; next state DONE.
- DONE: in_ready = 0. cw held stable. On the cw_ready & en edge:
  - state returns to ACC;
  - counter = 0;
  - parity region cleared to 0;
  - information region keeps stale data until it is overwritten.
- in_ready = en & (state == ACC). cw_valid = (state == DONE), regardless of en.
- status:
  - 00 when ACC with counter 0;
  - 01 when ACC with counter > 0;
  - 10 when DONE;
  - 11 never driven.
- mtx must be stable from the first accepted block until cw is consumed. Changing mtx mid-codeword gives an undefined codeword, but the block does not hang.

## Timing
- Reset (rst high at an edge): state ACC, counter 0, cw = 0, cw_valid = 0, status = 00. in_ready follows en from the next cycle.
- rst has priority over en and all handshakes. Reset mid-codeword discards partial parity. Reset while in DONE drops the pending codeword.
- Latency: cw_valid rises one cycle after the edge that accepts the last information block.
- Minimum period: KB+1 cycles per codeword (KB input beats + 1 DONE cycle with cw_ready held high).
- in_valid low or en low in ACC: stall, no state change, parity unchanged.
- cw_ready high while cw_valid is low: ignored.
- in_valid high while in DONE: not accepted; the source must hold in_data.
- KB = 1: the first beat goes straight to DONE.
- The parity XOR is a single combinational level per row: KB-independent, one rotation plus XOR per cycle.

## Test plan
- Reset check: rst held 2 cycles, en = 1 → cw = 0, cw_valid = 0, status = 00, in_ready = 1 the cycle after release.
- Basic encode, R=3, C=1, D=4, data_w=8, mtx row0 = {j0:1, j1:0}: send 4'b0001, then 4'b0010 → one cycle later cw_valid = 1, cw = 12'hA21, status = 10.
- Zero block: same setup but mtx[0][1] = 8'hFF → cw = 12'h821.
- Back-pressure and stalls: hold cw_ready = 0 for 5 cycles → cw stable and in_ready = 0. Toggle in_valid and en during ACC → parity identical to the unstalled run. cw_ready = 1 → the next codeword starts with parity 0.
- Reset mid-codeword: default parameters, rst after 5 of 12 blocks, then send a full codeword of random blocks → cw matches the reference-model XOR of rotations, with no contribution from the aborted blocks.
- Loopback, default parameters: 100 random codewords encoded, then fed (scaled to LLRs) into ldpc_core → every codeword reports check pass (status[0] = 0) with res == cw.
